seq_divider_eight_four: RTL and testbench
=========================================

Name: seq_divider_eight_four

Overview:
- Multi-cycle unsigned restoring divider: 8-bit dividend by 4-bit divisor, producing an 8-bit quotient and a 4-bit remainder.
- Inverse companion to the 4x4 Wallace-tree multiplier. Takes an 8-bit product and one of its 4-bit factors and recovers the other factor.
- Used for self-checking multiply/divide round trips in the arithmetic datapath.
- Start/done handshake; one quotient bit resolved per clock.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width.
- DIVISOR_W, 4, divisor and remainder width.
- CNT_W, 3, iteration counter width; must hold DIVIDEND_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  DIVIDEND_W  numerator; captured when start is accepted
- divisor  input  DIVISOR_W  denominator; captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; results valid
- div_by_zero  output  1  error flag; valid with done
- quotient  output  DIVIDEND_W  result
- remainder  output  DIVISOR_W  result

Behaviour:
- Reset: one clock, synchronous, active-high. rst high at an edge forces state=IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, counter=0.
- rst has priority over every other input, including mid-RUN. An aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and divisor!=0: capture dividend into a shift register and divisor into a holding register. Clear the partial remainder (DIVISOR_W+1 bits) and the counter. Go to RUN.
  - start=1 and divisor==0: go to DONE with quotient=8'hFF, remainder=0, div_by_zero=1.
- RUN, each edge:
  - Shift {partial remainder, dividend shift register} left by one.
  - Trial-subtract divisor from the shifted partial remainder.
  - If the result is non-negative, keep it and shift a 1 into the quotient LSB; otherwise restore and shift in a 0.
  - Counter increments. After the 8th iteration (counter==7 at the edge), go to DONE.
- DONE:
  - done=1 for exactly one cycle; quotient and remainder already hold final values.
  - Next edge returns to IDLE.
- Latency:
  - Start accepted at edge E0; busy=1 after E0 through E8.
  - done=1 in the cycle after E8 (8 clocks after acceptance), busy=0 in that cycle.
  - Divide-by-zero: done in the cycle after E0 (1 clock).
- Results: quotient, remainder and div_by_zero hold their values after DONE until the next accepted start. div_by_zero clears on the next accepted start that has a non-zero divisor.
- Ignored requests: start is ignored in RUN and DONE. It is neither queued nor able to corrupt the operation in flight. dividend/divisor changes after acceptance have no effect.
- Back-to-back: start held high continuously is accepted in each IDLE cycle, so throughput is one result per 10 clocks.
- Arithmetic:
  - Unsigned only. Partial remainder is DIVISOR_W+1 bits so the trial subtraction never overflows.
  - Invariant: quotient*divisor + remainder == dividend and remainder < divisor.
  - For dividend < divisor: quotient=0, remainder=dividend[3:0].

Test Plan:
- Reset, then dividend=8'd90 (0x5A), divisor=4'b1001, 1-cycle start -> busy 8 cycles; done pulse; quotient=8'd10, remainder=0, div_by_zero=0.
- dividend=8'd99, divisor=4'b1011 -> quotient=9, remainder=0. Next op 8'd255/4'd7 -> quotient=36, remainder=3, both after exactly 8 clocks.
- dividend=8'd5, divisor=4'd9 -> quotient=0, remainder=5. dividend=8'd9, divisor=4'd1 -> quotient=9, remainder=0.
- dividend=8'd200, divisor=0 -> done one cycle after start; div_by_zero=1, quotient=8'hFF, remainder=0. Follow with 90/9 -> div_by_zero returns to 0.
- Running 90/9: pulse start with 255/7 at cycle 3, change the inputs, and assert rst at cycle 5 -> no done; all outputs 0 next cycle. A fresh 99/11 afterwards yields 9 r 0.
- Exhaustive check: all 256x15 non-zero-divisor pairs, start held high -> every result satisfies q*d+r==n and r<d, with one done every 10 clocks.

Source files
------------

// File: rtl/seq_divider_eight_four.sv
// rtl/seq_divider_eight_four.sv - multi-cycle unsigned restoring divider, 8-bit dividend by 4-bit divisor
module seq_divider_eight_four #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    state_t                state_q;
    // Dividend shifts out of the top while quotient bits shift in at the bottom.
    logic [DIVIDEND_W-1:0] acc_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  dbz_q;

    logic [DIVISOR_W:0]    shifted_d;
    logic                  fits_d;
    logic [DIVISOR_W-1:0]  rem_d;
    logic [DIVIDEND_W-1:0] acc_d;

    // Stored remainder is always below the divisor, so the shifted partial needs one extra bit.
    always_comb begin
        shifted_d = {rem_q, acc_q[DIVIDEND_W-1]};
        fits_d    = (shifted_d >= {1'b0, dvs_q});
        rem_d     = fits_d ? DIVISOR_W'(shifted_d - {1'b0, dvs_q})
                           : shifted_d[DIVISOR_W-1:0];
        acc_d     = {acc_q[DIVIDEND_W-2:0], fits_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (divisor != '0) begin
                            acc_q   <= dividend;
                            dvs_q   <= divisor;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            acc_q   <= '1;
                            rem_q   <= '0;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = acc_q;
    assign remainder   = rem_q;

endmodule

// File: tb/tb_seq_divider_eight_four.sv
// tb/tb_seq_divider_eight_four.sv - scoreboard bench for seq_divider_eight_four
module tb_seq_divider_eight_four;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic [7:0] quotient;
    logic [3:0] remainder;

    seq_divider_eight_four dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         acc;
        int         lat;
        int         busy_n;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   b2b = 1'b0;
    int   last_done = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: plain integer division, with the fixed divide-by-zero answer.
    function automatic exp_t model(input int n, input int d);
        exp_t e;
        if (d == 0) begin
            e.q = 8'hFF; e.r = 4'd0; e.z = 1'b1; e.lat = 0; e.busy_n = 0;
        end else begin
            e.q = 8'(n / d); e.r = 4'(n % d); e.z = 1'b0; e.lat = 8; e.busy_n = 8;
        end
        e.acc = 0;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents done.
    initial begin
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("quotient", 32'(quotient), 32'(e.q));
                        check("remainder", 32'(remainder), 32'(e.r));
                        check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                        check("latency", 32'(cyc - e.acc), 32'(e.lat));
                        check("busy_at_done", 32'(busy), 32'd0);
                        check("busy_cycles", 32'(busy_cnt), 32'(e.busy_n));
                        if (b2b) begin
                            if (last_done >= 0) check("b2b_spacing", 32'(cyc - last_done), 32'd10);
                            last_done = cyc;
                        end
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic do_op(input int n, input int d, input bit hold);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (busy || done) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                check("idle_timeout", 32'(busy), 32'd0);
                return;
            end
        end
        dividend = 8'(n);
        divisor  = 4'(d);
        start    = 1'b1;
        e = model(n, d);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) begin
            start    = 1'b0;
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'd0);
        check({tag, "_remainder"}, 32'(remainder), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        do_op(90, 9, 0);   drain();
        do_op(99, 11, 0);  drain();
        do_op(255, 7, 0);  drain();
        do_op(5, 9, 0);    drain();
        do_op(9, 1, 0);    drain();
        do_op(200, 0, 0);  drain();
        do_op(90, 9, 0);   drain();

        // Abort mid-run: ignored start pulse, changing inputs, then reset.
        do_op(90, 9, 0);
        @(negedge clk);
        start = 1'b1; dividend = 8'd255; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0; dividend = 8'd77; divisor = 4'd3;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check_zero("abort");
        repeat (20) @(negedge clk);
        do_op(99, 11, 0);  drain();

        for (int i = 0; i < 60; i++) begin
            do_op(int'($urandom_range(255)), ($urandom_range(7) == 0) ? 0 : int'($urandom_range(15, 1)), 0);
            if ($urandom_range(1) == 1) drain();
        end
        drain();

        b2b = 1'b1;
        last_done = -1;
        for (int n = 0; n < 256; n++) begin
            for (int d = 1; d < 16; d++) begin
                do_op(n, d, 1);
            end
        end
        start = 1'b0;
        drain();
        b2b = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
